prog_loader: RTL

Boot-time program loader that sits directly upstream of `computer`. It receives a framed byte stream over a valid/ready handshake and writes the decoded instruction words into the program ROM's write port. It holds the CPU in reset until the whole image has loaded and the checksum verifies. It can be restarted to reload the ROM without a global reset.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: FSM encodings, the
// length-field width and default geometry.
package prog_loader_pkg;

    localparam int DEFAULT_PROG_ADDR_SIZE = 8;
    localparam int DEFAULT_WORD_SIZE      = 16;
    localparam int PL_LEN_WIDTH           = 16;

    localparam logic [2:0] PL_LEN_HI = 3'd0;
    localparam logic [2:0] PL_LEN_LO = 3'd1;
    localparam logic [2:0] PL_DATA   = 3'd2;
    localparam logic [2:0] PL_CSUM   = 3'd3;
    localparam logic [2:0] PL_DONE   = 3'd4;
    localparam logic [2:0] PL_ERR    = 3'd5;

    // Terminal states stop consuming the stream until a restart.
    function automatic logic pl_accepting(input logic [2:0] s);
        return (s != PL_DONE) && (s != PL_ERR);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: decodes LEN / words / CSUM, writes words
// into the program ROM and holds the CPU in reset until the image verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ProgAddrSize = DEFAULT_PROG_ADDR_SIZE,
    parameter int WordSize     = DEFAULT_WORD_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    rom_we,
    output logic [ProgAddrSize-1:0] rom_addr,
    output logic [WordSize-1:0]     rom_wdata,
    output logic                    cpu_reset,
    output logic                    done,
    output logic                    error,
    output logic [2:0]              dbg_state
);

    localparam int BPW = WordSize / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
    localparam longint unsigned MAX_WORDS = 64'd1 << ProgAddrSize;

    logic [2:0]              state;
    logic [7:0]              sum;
    logic [7:0]              len_hi;
    logic [PL_LEN_WIDTH-1:0] words_left;
    logic [BCW-1:0]          byte_cnt;
    logic [WordSize-1:0]     shreg;

    logic                    accept;
    logic [7:0]              sum_next;
    logic [PL_LEN_WIDTH-1:0] len_full;
    logic [WordSize-1:0]     word_next;

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    assign accept    = in_valid && in_ready;
    assign sum_next  = sum + in_data;
    assign len_full  = {len_hi, in_data};
    assign word_next = (shreg << 8) | WordSize'(in_data);

    assign in_ready  = pl_accepting(state);
    assign cpu_reset = (state != PL_DONE);
    assign done      = (state == PL_DONE);
    assign error     = (state == PL_ERR);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PL_LEN_HI;
            sum        <= 8'h00;
            len_hi     <= 8'h00;
            words_left <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
        end else begin
            rom_we <= 1'b0;
            // The address moves on after the write cycle, so it is stable while rom_we is high.
            if (rom_we) begin
                rom_addr <= rom_addr + ProgAddrSize'(1);
            end
            case (state)
                PL_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_data;
                        sum    <= sum_next;
                        state  <= PL_LEN_LO;
                    end
                end
                PL_LEN_LO: begin
                    if (accept) begin
                        sum <= sum_next;
                        if (64'(len_full) > MAX_WORDS) begin
                            state <= PL_ERR;
                        end else if (len_full == '0) begin
                            state <= PL_CSUM;
                        end else begin
                            words_left <= len_full;
                            byte_cnt   <= '0;
                            state      <= PL_DATA;
                        end
                    end
                end
                PL_DATA: begin
                    if (accept) begin
                        sum <= sum_next;
                        if (byte_cnt == BYTE_LAST) begin
                            rom_we     <= 1'b1;
                            rom_wdata  <= word_next;
                            byte_cnt   <= '0;
                            words_left <= words_left - PL_LEN_WIDTH'(1);
                            if (words_left == PL_LEN_WIDTH'(1)) begin
                                state <= PL_CSUM;
                            end
                        end else begin
                            shreg    <= word_next;
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                PL_CSUM: begin
                    if (accept) begin
                        sum   <= sum_next;
                        state <= (sum_next == 8'h00) ? PL_DONE : PL_ERR;
                    end
                end
                PL_DONE, PL_ERR: begin
                    if (start) begin
                        state    <= PL_LEN_HI;
                        sum      <= 8'h00;
                        rom_addr <= '0;
                    end
                end
                default: state <= PL_LEN_HI;
            endcase
        end
    end

endmodule
